serial_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 13 +
 rtl/full_sub_cell.sv | 21 ++
 rtl/serial_subtractor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Signed overflow output is enabled by SERIAL_SUB_SIGNED_EN.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } serial_sub_state_t;

    localparam int SERIAL_SUB_DEFAULT_W = 8;

endpackage

// File: rtl/full_sub_cell.sv
// Single-bit full subtractor: a - b - bin.
// Two cascaded half-subtract stages plus borrow OR.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    assign d1   = a ^ b;
    assign b1   = ~a & b;
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, LSB first, one bit per clock.
// Define SERIAL_SUB_SIGNED_EN to add the signed overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int W = SERIAL_SUB_DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         borrow_out
`ifdef SERIAL_SUB_SIGNED_EN
    ,
    output logic         overflow
`endif
);

    localparam int CW = $clog2(W);

    serial_sub_state_t state_q, state_d;

    logic [W-1:0]  a_sr_q, a_sr_d;
    logic [W-1:0]  b_sr_q, b_sr_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  diff_q, diff_d;
    logic          bin_q, bin_d;
    logic          bout_q, bout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          d;
    logic          bnext;
    logic          last;
`ifdef SERIAL_SUB_SIGNED_EN
    logic          ovf_q, ovf_d;
`endif

    full_sub_cell u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (bin_q),
        .d    (d),
        .bout (bnext)
    );

    assign last = (cnt_q == CW'(W - 1));

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bin_d   = bin_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_SUB_SIGNED_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d  = {d, res_q[W-1:1]};
                a_sr_d = {1'b0, a_sr_q[W-1:1]};
                b_sr_d = {1'b0, b_sr_q[W-1:1]};
                bin_d  = bnext;
                // Park the counter at zero so it never runs past W-1.
                cnt_d  = last ? '0 : cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    diff_d  = res_d;
                    bout_d  = bnext;
`ifdef SERIAL_SUB_SIGNED_EN
                    ovf_d   = (a_sr_q[0] != b_sr_q[0])
                            & (d != a_sr_q[0]);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bin_q   <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_SIGNED_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bin_q   <= bin_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_SIGNED_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
`ifdef SERIAL_SUB_SIGNED_EN
    assign overflow   = ovf_q;
`endif

endmodule
